// File: rtl/mest_pro_imem.sv
// mest_pro_imem: instruction memory that the processor fetches from and a
// byte-serial host loader fills at run time.
// Fetches are served only in IDLE and return data one cycle after the request.
// The loader packs four bytes, MSB first, into each word. It stops on the
// byte marked last, or when the final word of the memory has been written.
module mest_pro_imem #(
  parameter  int OP_CODE_SIZE     = 4,
  parameter  int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
  parameter  int ROM_DEPTH        = 256,
  localparam int AW               = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_req,
  input  logic [AW-1:0]               i_prog_counter,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_instr_valid,
  output logic                        o_fetch_err,
  input  logic                        i_load_start,
  input  logic                        i_load_byte_valid,
  input  logic [7:0]                  i_load_byte,
  input  logic                        i_load_last,
  output logic                        o_load_busy,
  output logic                        o_load_done,
  output logic [AW:0]                 o_load_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [INSTRUCTION_SIZE-1:0] mem_r [ROM_DEPTH];

  logic [0:0]                  state_r;
  logic [AW-1:0]               wptr_r;
  logic [1:0]                  byte_idx_r;
  logic [23:0]                 staging_r;   // bytes 0..2 of the word being built
  logic [AW:0]                 count_r;
  logic                        busy_r;
  logic                        done_r;
  logic                        instr_valid_r;
  logic                        fetch_err_r;
  logic [INSTRUCTION_SIZE-1:0] instruction_r;

  logic                        byte_acc_s;
  logic                        write_s;
  logic                        finish_s;
  logic                        full_s;
  logic                        fetch_s;
  logic [31:0]                 word_s;

  // Loader qualification: a start in the same cycle as a byte drops that byte
  always_comb begin
    byte_acc_s = (state_r == ST_LOAD) && i_load_byte_valid && !i_load_start;
    full_s     = (wptr_r == AW'(ROM_DEPTH - 1));
    write_s    = byte_acc_s && ((byte_idx_r == 2'd3) || i_load_last);
    finish_s   = write_s && (i_load_last || full_s);
    fetch_s    = i_req && (state_r == ST_IDLE);
  end

  // Merge the incoming byte into the staged bytes; missing low bytes read as zero
  always_comb begin
    case (byte_idx_r)
      2'd0:    word_s = {i_load_byte, 24'h000000};
      2'd1:    word_s = {staging_r[23:16], i_load_byte, 16'h0000};
      2'd2:    word_s = {staging_r[23:8], i_load_byte, 8'h00};
      2'd3:    word_s = {staging_r, i_load_byte};
      default: word_s = 32'h00000000;
    endcase
  end

  // Memory array write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wptr_r] <= INSTRUCTION_SIZE'(word_s);
    end
  end

  // Fetch pipeline: read in IDLE, reject with an error pulse while loading
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      instruction_r <= '0;
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
    end else begin
      instr_valid_r <= fetch_s;
      fetch_err_r   <= i_req && (state_r == ST_LOAD);
      if (fetch_s) begin
        instruction_r <= mem_r[i_prog_counter];
      end
    end
  end

  // Load controller: state, write pointer, byte index, word count and status
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      wptr_r     <= '0;
      byte_idx_r <= 2'd0;
      staging_r  <= 24'h000000;
      count_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_load_start) begin
            state_r    <= ST_LOAD;
            busy_r     <= 1'b1;
            wptr_r     <= '0;
            byte_idx_r <= 2'd0;
            count_r    <= '0;
          end
        end
        ST_LOAD: begin
          if (i_load_start) begin
            // restart: the partial word is simply never written
            wptr_r     <= '0;
            byte_idx_r <= 2'd0;
            count_r    <= '0;
          end else if (byte_acc_s) begin
            if (write_s) begin
              byte_idx_r <= 2'd0;
              count_r    <= count_r + (AW + 1)'(1);
              // hold the pointer on the last word so it only wraps on restart
              if (!full_s) begin
                wptr_r <= wptr_r + AW'(1);
              end
              if (finish_s) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end else begin
              staging_r  <= word_s[31:8];
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_instruction = instruction_r;
  assign o_instr_valid = instr_valid_r;
  assign o_fetch_err   = fetch_err_r;
  assign o_load_busy   = busy_r;
  assign o_load_done   = done_r;
  assign o_load_count  = count_r;

endmodule

// File: tb/tb_mest_pro_imem.sv
// Testbench for mest_pro_imem: directed scenarios plus random traffic.
// Each cycle the outputs are compared with a word-level model of the memory
// and loader.
module tb_mest_pro_imem;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0;
  logic [7:0]  i_prog_counter = 8'd0;
  logic [27:0] o_instruction;
  logic        o_instr_valid;
  logic        o_fetch_err;
  logic        i_load_start = 1'b0;
  logic        i_load_byte_valid = 1'b0;
  logic [7:0]  i_load_byte = 8'd0;
  logic        i_load_last = 1'b0;
  logic        o_load_busy;
  logic        o_load_done;
  logic [8:0]  o_load_count;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  mest_pro_imem dut (
    .clk(clk), .i_reset(i_reset), .i_req(i_req), .i_prog_counter(i_prog_counter),
    .o_instruction(o_instruction), .o_instr_valid(o_instr_valid), .o_fetch_err(o_fetch_err),
    .i_load_start(i_load_start), .i_load_byte_valid(i_load_byte_valid),
    .i_load_byte(i_load_byte), .i_load_last(i_load_last),
    .o_load_busy(o_load_busy), .o_load_done(o_load_done), .o_load_count(o_load_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [27:0] mmem [256];
  bit          mknown [256];
  bit          loading = 1'b0;
  logic [7:0]  cur [$];
  int          wcount = 0;
  int          wptr = 0;
  bit          exp_valid = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
  logic [27:0] exp_instr = 28'd0;
  bit          exp_instr_known = 1'b1;

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      loading = 1'b0; cur.delete(); wcount = 0; wptr = 0;
      exp_valid = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
      exp_instr = 28'd0; exp_instr_known = 1'b1;
    end else begin
      exp_valid = i_req && !loading;
      exp_err   = i_req && loading;
      exp_done  = 1'b0;
      if (exp_valid) begin
        exp_instr       = mmem[i_prog_counter];
        exp_instr_known = mknown[i_prog_counter];
      end
      if (i_load_start) begin
        loading = 1'b1; cur.delete(); wcount = 0; wptr = 0;
      end else if (loading && i_load_byte_valid) begin
        cur.push_back(i_load_byte);
        if (cur.size() == 4 || i_load_last) begin
          logic [31:0] w;
          w = 32'd0;
          foreach (cur[k]) w[31-8*k -: 8] = cur[k];
          mmem[wptr] = w[27:0];
          mknown[wptr] = 1'b1;
          wptr++; wcount++;
          cur.delete();
          if (i_load_last || wcount == 256) begin
            loading = 1'b0; exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (o_load_done === 1'b1) done_pulses++;
    chk("instr_valid", {31'd0, o_instr_valid}, {31'd0, exp_valid});
    chk("fetch_err", {31'd0, o_fetch_err}, {31'd0, exp_err});
    chk("load_busy", {31'd0, o_load_busy}, {31'd0, loading});
    chk("load_done", {31'd0, o_load_done}, {31'd0, exp_done});
    chk("load_count", {23'd0, o_load_count}, wcount);
    if (exp_instr_known) chk("instruction", {4'd0, o_instruction}, {4'd0, exp_instr});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic st, input logic bv, input logic [7:0] b,
                       input logic lst, input logic rq, input logic [7:0] pc);
    @(negedge clk);
    i_load_start = st; i_load_byte_valid = bv; i_load_byte = b;
    i_load_last = lst; i_req = rq; i_prog_counter = pc;
  endtask

  task automatic idle1();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic put(input logic [7:0] b, input logic lst);
    drive(1'b0, 1'b1, b, lst, 1'b0, 8'h00);
  endtask

  task automatic fetch_lit(input logic [7:0] pc, input logic [27:0] exp, input string name);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, pc);
    idle1();
    chk({name, "_valid"}, {31'd0, o_instr_valid}, 32'd1);
    chk(name, {4'd0, o_instruction}, {4'd0, exp});
  endtask

  initial begin
    int d0;
    foreach (mknown[k]) mknown[k] = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    chk("reset_count", {23'd0, o_load_count}, 32'd0);
    chk("reset_busy", {31'd0, o_load_busy}, 32'd0);

    // three-word load, last on byte 12
    d0 = done_pulses;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    put(8'h0A, 0); put(8'hBC, 0); put(8'hDE, 0); put(8'hF1, 0);
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
    put(8'h0F, 0); put(8'hFF, 0); put(8'hFF, 0); put(8'hFF, 1);
    idle1();
    chk("load3_done", {31'd0, o_load_done}, 32'd1);
    chk("load3_count", {23'd0, o_load_count}, 32'd3);
    idle1();
    chk("load3_done_once", done_pulses - d0, 32'd1);
    fetch_lit(8'd0, 28'hABCDEF1, "w0");
    fetch_lit(8'd1, 28'h1020304, "w1");
    fetch_lit(8'd2, 28'hFFFFFFF, "w2");

    // reset, then back-to-back fetches of the loaded contents
    @(negedge clk); #1 i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    for (int p = 0; p < 4; p++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(p));
    idle1(); idle1();

    // last on second byte: zero-filled word
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    put(8'h05, 0); put(8'h66, 1);
    idle1();
    chk("short_count", {23'd0, o_load_count}, 32'd1);
    fetch_lit(8'd0, 28'h5660000, "short_w0");

    // fetch during LOAD is rejected
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01);
    idle1();
    chk("err_pulse", {31'd0, o_fetch_err}, 32'd1);
    chk("err_novalid", {31'd0, o_instr_valid}, 32'd0);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 1);
    idle1();
    // start together with a fetch in IDLE: old data served, busy rises
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    idle1();
    chk("sim_valid", {31'd0, o_instr_valid}, 32'd1);
    chk("sim_data", {4'd0, o_instruction}, 32'h1223344);
    chk("sim_busy", {31'd0, o_load_busy}, 32'd1);
    put(8'hA5, 0); put(8'h5A, 0); put(8'hC3, 0); put(8'h3C, 1);
    idle1();
    fetch_lit(8'd0, 28'h55AC33C, "sim_w0");

    // restart after six bytes
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) put(8'(8'h10 + k), 0);
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);  // byte alongside start is dropped
    put(8'h21, 0); put(8'h22, 0); put(8'h23, 0); put(8'h24, 1);
    idle1();
    chk("restart_count", {23'd0, o_load_count}, 32'd1);
    fetch_lit(8'd0, 28'h1222324, "restart_w0");
    fetch_lit(8'd1, 28'h1020304, "restart_w1");

    // reset mid-load after two bytes
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    put(8'h77, 0); put(8'h88, 0);
    @(negedge clk); i_load_byte_valid = 1'b0; #1 i_reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, o_load_busy}, 32'd0);
    chk("rst_count", {23'd0, o_load_count}, 32'd0);
    @(negedge clk); i_reset = 1'b0;
    fetch_lit(8'd0, 28'h1222324, "rst_w0");

    // random traffic
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
    end
    idle1();

    // 1024-byte stream without last: fills the memory
    d0 = done_pulses;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 1024; k++) put(8'(k), 0);
    for (int k = 0; k < 8; k++) put(8'hEE, 0);   // bytes after completion are ignored
    idle1();
    chk("full_done_once", done_pulses - d0, 32'd1);
    chk("full_count", {23'd0, o_load_count}, 32'd256);
    fetch_lit(8'd255, 28'hCFDFEFF, "full_w255");
    fetch_lit(8'd254, 28'h8F9FAFB, "full_w254");
    fetch_lit(8'd0, 28'h0010203, "full_w0");

    idle1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mest_pro_imem.md
# mest_pro_imem

Loadable instruction memory that answers the processor's fetch port. It returns the `INSTRUCTION_SIZE`-bit word at the requested program counter one cycle after a request. A byte-serial loader port fills the memory at run time, so the processor can run programs without resynthesising a ROM. The block sits between the processor fetch interface (request, program counter) and a host/boot loader.

## Interface

Parameters:
- `OP_CODE_SIZE`, 4, opcode field width (word MSBs).
- `INSTRUCTION_SIZE`, `OP_CODE_SIZE`+24 = 28, instruction word width; must be ≤ 32.
- `ROM_DEPTH`, 256, number of words; power of two.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request from processor.
- `i_prog_counter`  in  $clog2(ROM_DEPTH)  fetch address.
- `o_instruction`  out  INSTRUCTION_SIZE  fetched word.
- `o_instr_valid`  out  1  one-cycle pulse: `o_instruction` valid.
- `o_fetch_err`  out  1  one-cycle pulse: request rejected because a load is in progress.
- `i_load_start`  in  1  begin (or restart) a load at address 0.
- `i_load_byte_valid`  in  1  `i_load_byte` valid this cycle.
- `i_load_byte`  in  8  program byte, MSB-first within a word.
- `i_load_last`  in  1  qualifies the final byte of the program.
- `o_load_busy`  out  1  high while in LOAD.
- `o_load_done`  out  1  one-cycle pulse at load completion.
- `o_load_count`  out  $clog2(ROM_DEPTH)+1  words written by the current or last load.

## Operation

- FSM states: IDLE (serve fetches) and LOAD (accept bytes). Reset enters IDLE.
- Transitions:
  - IDLE→LOAD on `i_load_start`.
  - LOAD→LOAD (restart) on `i_load_start`: write pointer, byte index and count are cleared, and any partial word is discarded.
  - LOAD→IDLE after the final word write.
- Fetch in IDLE: `i_req` is sampled and `mem[i_prog_counter]` is registered into `o_instruction`. `o_instr_valid` is 1 on the following cycle.
- Fetch in LOAD:
  - `o_instr_valid` stays 0.
  - `o_fetch_err` pulses the following cycle.
  - `o_instruction` holds its last value.
- Loader assembles a word from 4 bytes, MSB-first (byte0 = bits 31:24 of a 32-bit staging word). The stored word is staging[INSTRUCTION_SIZE-1:0]; excess upper bits of byte0 are discarded.
- A word is written to `mem[wptr]` on the edge accepting byte index 3. Then wptr++ and `o_load_count`++.
- `i_load_last` with byte index < 3: the remaining low bytes are zero-filled and the word is written on that edge.
- Load completes on the write that carries `i_load_last`, or on the write of word `ROM_DEPTH`-1 (memory full). Full completion ignores further bytes.
- `i_load_byte_valid` in IDLE is ignored. Bytes with valid low are ignored in every state.
- `i_load_start` and `i_req` in the same IDLE cycle: the fetch is served from the current contents and the FSM enters LOAD.
- `i_load_start` and `i_load_byte_valid` in the same cycle: the byte is ignored and the load starts clean.
- Memory contents are not reset. Reset mid-load aborts the load: the partial word is lost, and words already written are retained.

## Timing

- Reset values:
  - `o_instruction` = 0
  - `o_instr_valid` = 0
  - `o_fetch_err` = 0
  - `o_load_busy` = 0
  - `o_load_done` = 0
  - `o_load_count` = 0
  - FSM = IDLE, wptr = 0, byte index = 0
- Fetch latency: 1 cycle, fully pipelined. Back-to-back requests give back-to-back valid pulses.
- Loader throughput: one byte per cycle, so one word per 4 cycles.
- `o_load_busy` rises the cycle after `i_load_start` and falls the cycle after the final write.
- `o_load_done` pulses in the same cycle that `o_load_busy` falls.
- A fetch in the first IDLE cycle after the load sees the newly written data.
- `o_load_count` is updated on the write edge and holds after done until the next `i_load_start` clears it.
- Width rule: `o_load_count` reaches `ROM_DEPTH` (256) without wrapping. wptr wraps to 0 only on restart.

## Test plan

- Reset, then fetch pc 0..3 on consecutive cycles. Outputs are 0 during reset. After reset, 4 consecutive valid pulses appear with data equal to the preloaded contents, each 1 cycle after its request.
- Load 3 words with bytes 0x0A,0xBC,0xDE,0xF1 / 0x01,0x02,0x03,0x04 / 0x0F,0xFF,0xFF,0xFF, last on byte 12.
  - `o_load_count` reaches 3 and `o_load_done` pulses once.
  - Fetch pc 0/1/2 returns 0xABCDEF1 / 0x1020304 / 0xFFFFFFF.
- Send `i_load_last` on the 2nd byte (0x05,0x66). Word 0 = 0x5660000 and `o_load_count` = 1.
- `i_req` during LOAD: `o_fetch_err` pulses once and `o_instr_valid` stays 0. Simultaneous `i_load_start` + `i_req` in IDLE: valid pulse with the old data, and busy rises.
- Restart and reset mid-load:
  - After 6 bytes, a restart followed by a 4-byte load gives count 1, word 0 = the new data, and word 1 unchanged.
  - Assert `i_reset` after 2 bytes: busy drops immediately, count = 0, and memory is retained.
- Stream 1024 bytes without last. Done pulses after word 255 with `o_load_count` = 256. Subsequent bytes are ignored, and pc 255 returns the last word.
